// File: rtl/fcb_pkg.sv
// Shared helpers for the flow-control FIFO family: pointer width and
// wrap-around pointer increment for arbitrary (non power-of-2) depths.
package fcb_pkg;

   function automatic int fcb_ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned fcb_next_ptr(input int unsigned ptr,
                                                input int unsigned depth);
      return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/ff_fifo_any_depth.sv
// Storage core for the flow-control FIFO: circular buffer of any depth with
// occupancy count, full/empty and synchronous flush. No handshake logic here.
module ff_fifo_any_depth
   import fcb_pkg::*;
#(
   parameter  int W     = 8,
   parameter  int DEPTH = 3,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  write_data,
   output logic [W-1:0]  read_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int            PW      = fcb_ptr_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = PW'(fcb_next_ptr(32'(wr_ptr_q), unsigned'(DEPTH)));
         if (pop)  rd_ptr_d = PW'(fcb_next_ptr(32'(rd_ptr_q), unsigned'(DEPTH)));
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset so it can map onto distributed/block RAM.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= write_data;
   end

   assign read_data = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);

`ifndef SYNTHESIS
   a_no_push_full:  assert property (@(posedge clk) disable iff (!rst) !(push && full));
   a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
   a_count_bounded: assert property (@(posedge clk) disable iff (!rst) count_q <= DEPTH_C);
`endif

endmodule

// File: rtl/fcb_6_param_fifo_bypass.sv
// Valid/ready FIFO wrapper: handshake gating, optional empty-bypass mux and
// almost_full around the any-depth storage core.
module fcb_6_param_fifo_bypass #(
   parameter  int W         = 8,
   parameter  int DEPTH     = 3,
   parameter  int BYPASS    = 0,
   parameter  int AF_THRESH = 2,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          up_vld,
   output logic          up_rdy,
   input  logic [W-1:0]  up_data,
   output logic          down_vld,
   input  logic          down_rdy,
   output logic [W-1:0]  down_data,
   output logic [CW-1:0] count,
   output logic          almost_full
);

   localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);

   logic          full, empty;
   logic          push, pop, pass_thru;
   logic          fifo_push, fifo_pop;
   logic [W-1:0]  rd_data;

   // up_rdy deliberately ignores down_rdy: a full FIFO never accepts.
   assign up_rdy = rst & ~full & ~flush;
   assign push   = up_vld & up_rdy;
   assign pop    = down_vld & down_rdy;

   generate
      if (BYPASS != 0) begin : g_bypass
         assign down_vld  = rst & ~flush & (~empty | up_vld);
         assign down_data = empty ? up_data : rd_data;
         assign pass_thru = empty & push & down_rdy;
      end else begin : g_registered
         assign down_vld  = rst & ~flush & ~empty;
         assign down_data = rd_data;
         assign pass_thru = 1'b0;
      end
   endgenerate

   // A word forwarded straight through never touches storage.
   assign fifo_push = push & ~pass_thru;
   assign fifo_pop  = pop & ~empty;

   ff_fifo_any_depth #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push),
      .pop        (fifo_pop),
      .flush      (flush),
      .write_data (up_data),
      .read_data  (rd_data),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   assign almost_full = (count >= AF_C);

endmodule

// File: tb/tb_fcb_6_param_fifo_bypass.sv
// Bench for the flow-control FIFO: registered (BYPASS=0) and bypass (BYPASS=1)
// instances, vector table plus hand sequences, data checked via scoreboard queues.
module tb_fcb_6_param_fifo_bypass;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush0, up_vld0, up_rdy0, down_vld0, down_rdy0, af0;
   logic [7:0] up_data0, down_data0;
   logic [1:0] count0;
   logic       flush1, up_vld1, up_rdy1, down_vld1, down_rdy1, af1;
   logic [7:0] up_data1, down_data1;
   logic [1:0] count1;

   int checks = 0;
   int errors = 0;
   int pops0  = 0;
   int pops1  = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   always #5 clk = ~clk;

   fcb_6_param_fifo_bypass #(.W(8), .DEPTH(3), .BYPASS(0), .AF_THRESH(2)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush0), .up_vld(up_vld0), .up_rdy(up_rdy0),
      .up_data(up_data0), .down_vld(down_vld0), .down_rdy(down_rdy0),
      .down_data(down_data0), .count(count0), .almost_full(af0));

   fcb_6_param_fifo_bypass #(.W(8), .DEPTH(3), .BYPASS(1), .AF_THRESH(2)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush1), .up_vld(up_vld1), .up_rdy(up_rdy1),
      .up_data(up_data1), .down_vld(down_vld1), .down_rdy(down_rdy1),
      .down_data(down_data1), .count(count1), .almost_full(af1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted words queued, popped words compared in order.
   always @(negedge clk) begin
      if (!rst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (up_vld0 && up_rdy0) q0.push_back(up_data0);
         if (down_vld0 && down_rdy0) begin
            if (q0.size() == 0) chk("sb0_underflow", 32'd1, 32'd0);
            else begin
               logic [7:0] e0;
               e0 = q0.pop_front();
               $display("dut0 pop data=%h exp=%h", down_data0, e0);
               chk("sb0_data", down_data0, e0);
            end
            pops0++;
         end
         if (flush0) q0.delete();
         if (up_vld1 && up_rdy1) q1.push_back(up_data1);
         if (down_vld1 && down_rdy1) begin
            if (q1.size() == 0) chk("sb1_underflow", 32'd1, 32'd0);
            else begin
               logic [7:0] e1;
               e1 = q1.pop_front();
               $display("dut1 pop data=%h exp=%h", down_data1, e1);
               chk("sb1_data", down_data1, e1);
            end
            pops1++;
         end
         if (flush1) q1.delete();
      end
   end

   typedef struct {
      logic       up_vld;
      logic [7:0] up_data;
      logic       down_rdy;
      logic       flush;
      logic       e_up_rdy;
      logic       e_down_vld;
      logic [1:0] e_count;
      logic       e_af;
   } vec_t;

   vec_t vec [12];

   initial begin
      int sent, cyc, pops_before;

      // fill, full, simultaneous-at-full, drain, then flush at count 2
      vec[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
      vec[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
      vec[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1};
      vec[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
      vec[4]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
      vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1};
      vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
      vec[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
      vec[8]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
      vec[9]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
      vec[10] = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
      vec[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};

      rst = 1'b0;
      flush0 = 1'b0; up_vld0 = 1'b0; up_data0 = 8'h00; down_rdy0 = 1'b0;
      flush1 = 1'b0; up_vld1 = 1'b1; up_data1 = 8'hEE; down_rdy1 = 1'b1;
      #3;
      chk("rst_up_rdy0", up_rdy0, 0);
      chk("rst_down_vld0", down_vld0, 0);
      chk("rst_count0", count0, 0);
      chk("rst_up_rdy1", up_rdy1, 0);
      chk("rst_down_vld1", down_vld1, 0);
      chk("rst_af0", af0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      up_vld1 = 1'b0;
      next_cycle();

      for (int i = 0; i < 12; i++) begin
         up_vld0 = vec[i].up_vld; up_data0 = vec[i].up_data;
         down_rdy0 = vec[i].down_rdy; flush0 = vec[i].flush;
         @(negedge clk);
         $display("vec %0d vld=%b data=%h rdy=%b flush=%b -> up_rdy=%b dvld=%b cnt=%0d af=%b",
                  i, up_vld0, up_data0, down_rdy0, flush0, up_rdy0, down_vld0, count0, af0);
         chk($sformatf("v%0d_up_rdy", i), up_rdy0, vec[i].e_up_rdy);
         chk($sformatf("v%0d_down_vld", i), down_vld0, vec[i].e_down_vld);
         chk($sformatf("v%0d_count", i), count0, vec[i].e_count);
         chk($sformatf("v%0d_af", i), af0, vec[i].e_af);
         next_cycle();
      end
      flush0 = 1'b0;

      // stream 10 words with down_rdy toggling; output order checked by scoreboard
      pops_before = pops0;
      sent = 0;
      cyc  = 0;
      while (sent < 10 && cyc < 200) begin
         up_vld0 = 1'b1;
         up_data0 = 8'(8'h80 + sent);
         down_rdy0 = (cyc % 2 == 0);
         @(negedge clk);
         if (up_rdy0) sent++;
         cyc++;
         next_cycle();
         chk("wrap_count", count0, q0.size());
      end
      chk("wrap_sent", sent, 10);
      up_vld0 = 1'b0;
      down_rdy0 = 1'b1;
      cyc = 0;
      while (q0.size() != 0 && cyc < 20) begin
         next_cycle();
         cyc++;
      end
      @(negedge clk);
      chk("wrap_pops", pops0 - pops_before, 10);
      chk("wrap_drained_count", count0, 0);
      chk("wrap_drained_vld", down_vld0, 0);
      next_cycle();

      // asynchronous reset between edges with two words held
      up_vld0 = 1'b1; up_data0 = 8'hC1; down_rdy0 = 1'b0;
      next_cycle();
      up_data0 = 8'hC2;
      next_cycle();
      chk("pre_rst_count", count0, 2);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count", count0, 0);
      chk("async_rst_down_vld", down_vld0, 0);
      chk("async_rst_up_rdy", up_rdy0, 0);
      @(negedge clk);
      next_cycle();
      rst = 1'b1;
      up_vld0 = 1'b0;
      next_cycle();
      chk("post_rst_count", count0, 0);

      // bypass instance: pass-through, write when stalled, then read from storage
      up_vld1 = 1'b1; up_data1 = 8'h5A; down_rdy1 = 1'b1;
      @(negedge clk);
      chk("byp_down_vld", down_vld1, 1);
      chk("byp_down_data", down_data1, 8'h5A);
      chk("byp_up_rdy", up_rdy1, 1);
      next_cycle();
      chk("byp_count_after", count1, 0);
      up_data1 = 8'h6B; down_rdy1 = 1'b0;
      @(negedge clk);
      chk("byp_stall_data", down_data1, 8'h6B);
      next_cycle();
      chk("byp_stall_count", count1, 1);
      up_data1 = 8'h7C; down_rdy1 = 1'b1;
      @(negedge clk);
      chk("byp_mem_data", down_data1, 8'h6B);
      next_cycle();
      chk("byp_both_count", count1, 1);
      up_vld1 = 1'b0;
      @(negedge clk);
      chk("byp_last_data", down_data1, 8'h7C);
      next_cycle();
      chk("byp_final_count", count1, 0);
      @(negedge clk);
      chk("byp_final_vld", down_vld1, 0);
      chk("byp_pops", pops1, 3);
      chk("sb_leftover", q0.size() + q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
